// File: rtl/boot_loader.sv
// boot_loader: receives a framed UART byte stream (A5, count_lo, count_hi,
// count x 4 little-endian payload bytes) and writes the assembled words into
// the fetch-stage instruction memory, holding the CPU off while loading.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module boot_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        debug,
   output logic [31:0] data_cpu,
   output logic [31:0] waddr_cpu,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned IDLE_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
`ifdef BOOT_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_e;

   // State entered once the payload (or an empty count) is complete.
`ifdef BOOT_CHECKSUM_EN
   localparam state_e FRAME_END = S_CHK;
`else
   localparam state_e FRAME_END = S_DONE;
`endif

   state_e            state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       widx_q, widx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [23:0]       word_q, word_d;
   logic              debug_q, debug_d;
   logic [31:0]       data_q, data_d;
   logic [15:0]       waddr_q, waddr_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign debug     = debug_q;
   assign data_cpu  = data_q;
   assign waddr_cpu = {16'h0000, waddr_q};
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign cpu_hold  = busy | err;
`ifdef BOOT_CHECKSUM_EN
   assign busy = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CHK);
`else
   assign busy = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                 (state_q == S_DATA);
`endif

   // Next-state, word assembly, write strobe and inter-byte timeout.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      debug_d = 1'b0;
      data_d  = data_q;
      waddr_d = waddr_q;
      idle_d  = idle_q;
`ifdef BOOT_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (rx_valid && (rx_data == 8'hA5)) begin
               state_d = S_CNT_LO;
               idle_d  = '0;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_CNT_LO: begin
            if (rx_valid) begin
               count_d[7:0] = rx_data;
               state_d      = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (rx_valid) begin
               count_d[15:8] = rx_data;
               widx_d        = '0;
               bidx_d        = '0;
               state_d       = ({rx_data, count_q[7:0]} == 16'h0000) ? FRAME_END : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
`ifdef BOOT_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               bidx_d = bidx_q + 2'd1;
               case (bidx_q)
                  2'd0:    word_d[7:0]   = rx_data;
                  2'd1:    word_d[15:8]  = rx_data;
                  2'd2:    word_d[23:16] = rx_data;
                  default: begin
                     data_d  = {rx_data, word_q};
                     waddr_d = widx_q;
                     debug_d = 1'b1;
                     widx_d  = widx_q + 16'd1;
                     if (widx_q == (count_q - 16'd1)) state_d = FRAME_END;
                  end
               endcase
            end
         end
`ifdef BOOT_CHECKSUM_EN
         S_CHK: begin
            if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Timeout overrides any transition only on a cycle with no byte.
      if (busy) begin
         if (rx_valid)                 idle_d  = '0;
         else if (idle_q == IDLE_LAST) state_d = S_ERR;
         else                          idle_d  = idle_q + 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         debug_q <= 1'b0;
         data_q  <= '0;
         waddr_q <= '0;
         idle_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         debug_q <= debug_d;
         data_q  <= data_d;
         waddr_q <= waddr_d;
         idle_q  <= idle_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: table of frames with expected status, a write
// scoreboard fed when frames are driven, plus hand-written timing sequences.
`timescale 1ns/1ps
module tb_boot_loader;

   localparam int unsigned TO = 50;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CKS_ON = 1'b1;
`else
   localparam bit CKS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        debug;
   logic [31:0] data_cpu;
   logic [31:0] waddr_cpu;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   boot_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .debug     (debug),
      .data_cpu  (data_cpu),
      .waddr_cpu (waddr_cpu),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   int unsigned n_cmp   = 0;
   int unsigned n_bad   = 0;
   int unsigned n_pulse = 0;
   logic [47:0] exp_q [$];
   logic        prev_dbg = 1'b0;

   typedef struct {
      int unsigned n;
      logic [31:0] w [4];
      logic        bad;
      logic        exp_done;
      logic        exp_err;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Write monitor: every debug pulse must match the oldest pending write.
   always @(negedge clk) begin
      if (debug) begin
         n_pulse++;
         check("debug_one_cycle", {31'b0, prev_dbg}, 32'd0);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write pending",
                     waddr_cpu, data_cpu);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            check("write_addr", waddr_cpu, {16'h0000, e[47:32]});
            check("write_data", data_cpu, e[31:0]);
         end
      end
      prev_dbg = debug;
   end

   task automatic put(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int unsigned n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_debug"}, {31'b0, debug}, 32'd0);
      check({tag, "_data"}, data_cpu, 32'd0);
      check({tag, "_waddr"}, waddr_cpu, 32'd0);
      check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd0);
      check({tag, "_err"}, {31'b0, err}, 32'd0);
   endtask

   task automatic set_row(input int unsigned idx, input int unsigned n,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3,
                          input logic bad, input logic ed, input logic ee);
      tbl[idx].n        = n;
      tbl[idx].w[0]     = w0;
      tbl[idx].w[1]     = w1;
      tbl[idx].w[2]     = w2;
      tbl[idx].w[3]     = w3;
      tbl[idx].bad      = bad;
      tbl[idx].exp_done = ed;
      tbl[idx].exp_err  = ee;
   endtask

   task automatic send_frame(input int unsigned row);
      logic [7:0]  cks;
      logic [31:0] wd;
      logic [15:0] n16;
      cks = 8'h00;
      n16 = tbl[row].n[15:0];
      put(8'hA5);
      put(n16[7:0]);
      put(n16[15:8]);
      for (int unsigned i = 0; i < tbl[row].n; i++) begin
         wd = tbl[row].w[i];
         exp_q.push_back({i[15:0], wd});
         for (int unsigned b = 0; b < 4; b++) begin
            put(wd[8*b +: 8]);
            cks = cks ^ wd[8*b +: 8];
         end
      end
      if (CKS_ON) put(tbl[row].bad ? ~cks : cks);
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  f [12];
      int unsigned nb;
      int unsigned p0;

      set_row(0, 2, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      set_row(1, 2, 32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, !CKS_ON, CKS_ON);
      set_row(2, 1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      set_row(3, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      set_row(4, 3, 32'h00000001, 32'hFFFFFFFF, 32'h80A50001, 32'h0, 1'b0, 1'b1, 1'b0);
      set_row(5, 4, 32'h000000A5, 32'hCAFEF00D, 32'h01020304, 32'h55AA33CC, 1'b1, !CKS_ON, CKS_ON);

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      idle(10);
      check_zero("reset");

      // Stray bytes outside a frame are ignored.
      put(8'h00);
      put(8'h12);
      idle(2);
      check("stray_busy", {31'b0, busy}, 32'd0);
      check("stray_hold", {31'b0, cpu_hold}, 32'd0);

      // Reference frame with per-byte cpu_hold timing.
      f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      nb = CKS_ON ? 12 : 11;
      p0 = n_pulse;
      exp_q.push_back({16'd0, 32'h12345678});
      exp_q.push_back({16'd1, 32'hDEADBEEF});
      for (int unsigned i = 0; i < nb; i++) begin
         put(f[i]);
         if (i < nb - 1) check("ref_hold_during", {31'b0, cpu_hold}, 32'd1);
      end
      rx_valid = 1'b0;
      check("ref_hold_release", {31'b0, cpu_hold}, 32'd0);
      check("ref_done", {31'b0, done}, 32'd1);
      check("ref_err", {31'b0, err}, 32'd0);
      idle(2);
      check("ref_pulses", n_pulse - p0, 32'd2);
      check("ref_pending", exp_q.size(), 32'd0);

      // Table of frames.
      for (int unsigned r = 0; r < 6; r++) begin
         p0 = n_pulse;
         send_frame(r);
         idle(2);
         check("tbl_done", {31'b0, done}, {31'b0, tbl[r].exp_done});
         check("tbl_err", {31'b0, err}, {31'b0, tbl[r].exp_err});
         check("tbl_hold", {31'b0, cpu_hold}, {31'b0, tbl[r].exp_err});
         check("tbl_busy", {31'b0, busy}, 32'd0);
         check("tbl_pulses", n_pulse - p0, tbl[r].n);
         check("tbl_pending", exp_q.size(), 32'd0);
      end

      // Inter-byte timeout inside the payload.
      p0 = n_pulse;
      put(8'hA5);
      put(8'h01);
      put(8'h00);
      put(8'h11);
      idle(TO - 1);
      check("to_err_early", {31'b0, err}, 32'd0);
      check("to_busy_early", {31'b0, busy}, 32'd1);
      idle(1);
      check("to_err", {31'b0, err}, 32'd1);
      check("to_hold", {31'b0, cpu_hold}, 32'd1);
      check("to_busy", {31'b0, busy}, 32'd0);
      check("to_done", {31'b0, done}, 32'd0);
      check("to_pulses", n_pulse - p0, 32'd0);

      // Reset after byte 6 of a 2-word frame, then a clean reload.
      put(8'hA5);
      put(8'h02);
      put(8'h00);
      put(8'h78);
      put(8'h56);
      put(8'h34);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_zero("midrst");
      rst = 1'b0;
      p0 = n_pulse;
      send_frame(0);
      idle(2);
      check("reload_done", {31'b0, done}, 32'd1);
      check("reload_pulses", n_pulse - p0, 32'd2);
      check("reload_pending", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Bootloader writer for the instruction memory in the fetch stage. Receives a framed byte stream from the UART receiver, assembles little-endian 32-bit words, and issues one-cycle write strobes on `debug`/`data_cpu`/`waddr_cpu`, which the fetch stage samples on the following negedge. Holds the CPU off via `cpu_hold` for the duration of a load and releases it when the load completes.

## Interface
- `TIMEOUT_CYCLES`, default 100000: maximum number of idle clk cycles allowed between bytes inside a frame.
- `clk`  in  1  system clock; all logic is on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per byte. No backpressure: every strobe is consumed.
- `debug`  out  1  instruction-memory write strobe, one clk cycle per word.
- `data_cpu`  out  32  write data; held until the next word completes.
- `waddr_cpu`  out  32  word address (`[31:16]` always 0); held like `data_cpu`.
- `cpu_hold`  out  1  high while a load is in progress or failed; drives the PC stall / CPU reset.
- `busy`  out  1  FSM is in CNT_LO, CNT_HI, DATA or CHK.
- `done`  out  1  last frame completed successfully.
- `err`  out  1  last frame failed (checksum mismatch or timeout).

## Operation
- Frame format: `0xA5`, count_lo, count_hi, then count×4 payload bytes (LSB first per word), then a checksum byte when the checksum feature is enabled. Count is 16-bit, range 0..65535.
- FSM states and transitions:
  - IDLE / DONE / ERR: `rx_valid` with `0xA5` → CNT_LO. Any other byte is ignored.
  - CNT_LO: byte → count[7:0] → CNT_HI.
  - CNT_HI: byte → count[15:8]. If count == 0 → CHK (checksum enabled) or DONE. Otherwise → DATA, with word_idx = 0 and byte_idx = 0.
  - DATA: byte_idx 0..3 fills bits [7:0], [15:8], [23:16], [31:24]. On byte_idx 3: `data_cpu` ← assembled word, `waddr_cpu` ← word_idx, `debug` = 1 for the next cycle, word_idx++. If word_idx == count−1 → CHK or DONE.
  - CHK: byte == XOR of all payload bytes → DONE; otherwise → ERR.
- The checksum accumulator clears on `0xA5` detection. Count bytes are not included in the checksum.
- `0xA5` entering CNT_LO clears `done` and `err` and sets `cpu_hold`.
- DONE: `cpu_hold` = 0, `done` = 1.
- ERR: `cpu_hold` stays 1, `err` = 1. The CPU does not run a partial image.
- Timeout: in CNT_LO, CNT_HI, DATA or CHK, the idle counter resets on each `rx_valid` and increments otherwise. At TIMEOUT_CYCLES → ERR. The counter is 17 bits wide minimum, sized by `$clog2`.
- `0xA5` is treated as data (no restart) in CNT_LO, CNT_HI, DATA and CHK.

## Timing
- Reset values: `debug` 0, `data_cpu` 0, `waddr_cpu` 0, `cpu_hold` 0 (the preloaded image runs), `busy` 0, `done` 0, `err` 0; FSM in IDLE.
- Write latency: `debug`, `data_cpu` and `waddr_cpu` update on the posedge after the clk edge that samples the 4th byte. `debug` is high for exactly one cycle, and address and data are stable for that whole cycle, including its negedge.
- `cpu_hold` rises one cycle after `0xA5` is sampled. It falls one cycle after the final byte is sampled (last data byte, or checksum byte when the checksum feature is enabled).
- Back-to-back `rx_valid` on consecutive cycles is supported at full rate.
- A byte arriving while `debug` is high is processed normally.
- `rst` mid-frame: all outputs return to their reset values on the next edge, and any partial word is discarded.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - The CHK state and XOR accumulator are present.
  - One trailing checksum byte is required per frame.
  - A mismatch → ERR.
- `BOOT_CHECKSUM_EN` not defined:
  - No CHK state or accumulator is built.
  - The frame ends after the last payload byte, or directly after count_hi when count == 0.
  - `err` is set only by timeout.

## Test plan
- Reset, then idle 10 cycles → all outputs 0; no `debug` pulse.
- `0x00`, `0x12`, then `A5 02 00 78 56 34 12 EF BE AD DE 2A` (checksum enabled) → exactly two `debug` pulses: (addr 0, data 0x12345678) and (addr 1, data 0xDEADBEEF). `cpu_hold` high from `A5` until one cycle after `2A`. `done` = 1, `err` = 0.
- Same frame with final byte `0x00` → both writes occur, then `err` = 1, `cpu_hold` stays 1, `done` = 0. A following valid frame → `done` = 1.
- `A5 01 00 11`, then no `rx_valid` for TIMEOUT_CYCLES (set to 50 in the bench) → `err` = 1 at cycle 50. No `debug` pulse occurs.
- `A5 00 00 00` → `done` = 1 and zero `debug` pulses. Repeat without the checksum feature using `A5 00 00` → same result.
- `rst` asserted after byte 6 of a 2-word frame → all outputs 0 on the next edge. A subsequent full frame writes addr 0/1 correctly.
